core_ifu: RTL and testbench
===========================

CORE_IFU -- requirements
Module: core_ifu

Interface
- REQ-001: The module SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum number of wait cycles per memory read (used only with CORE_IFU_WAIT_TIMEOUT_EN).
- REQ-002: The module SHALL have port ifu_clock_mem_i, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: The module SHALL have port ifu_reset_i, input, 1 bit: synchronous, active-high reset.
- REQ-004: The module SHALL have port ifu_en_i, input, 1 bit: fetch enable; when low, no new memory read is issued.
- REQ-005: The module SHALL have port ifu_flush_i, input, 1 bit: PC discontinuity; restart fetch at ifu_pc_i.
- REQ-006: The module SHALL have port ifu_pc_i, input, 16 bits: fetch address loaded on flush.
- REQ-007: The module SHALL have port ifu_mem_addr_o, output, 16 bits: program memory read address.
- REQ-008: The module SHALL have port ifu_mem_rd_o, output, 1 bit: read request.
- REQ-009: The module SHALL have port ifu_mem_data_i, input, 8 bits: read data.
- REQ-010: The module SHALL have port ifu_mem_ack_i, input, 1 bit: read data valid for the current request.
- REQ-011: The module SHALL have port ifu_byte_o, output, 8 bits: head-of-buffer instruction byte.
- REQ-012: The module SHALL have port ifu_byte_addr_o, output, 16 bits: address of ifu_byte_o.
- REQ-013: The module SHALL have port ifu_byte_valid_o, output, 1 bit: head entry valid.
- REQ-014: The module SHALL have port ifu_byte_ready_i, input, 1 bit: the consumer pops the head when valid and ready are both high.
- REQ-015: The module SHALL have port ifu_fault_o, output, 1 bit: sticky memory-timeout fault; tied 0 without the macro.

Function
- REQ-016: The module SHALL hold a 2-entry FIFO of {byte, address} pairs and a 16-bit fetch pointer.
- REQ-017: The FSM SHALL have exactly three states: IDLE, FETCH and FULL.
- REQ-018: From IDLE, the FSM SHALL go to FETCH when ifu_en_i=1 and FIFO count < 2, and to FULL when ifu_en_i=1 and count = 2.
- REQ-019: In FETCH, ifu_mem_rd_o SHALL be 1 and ifu_mem_addr_o SHALL equal the fetch pointer, both held stable until ifu_mem_ack_i=1 is sampled.
- REQ-020: On an accepted ack, the module SHALL push {ifu_mem_data_i, pointer} and increment the pointer modulo 2^16 (0xFFFF wraps to 0x0000).
- REQ-021: After an ack, the FSM SHALL stay in FETCH if ifu_en_i=1 and the post-update count < 2, go to FULL if the count = 2, and go to IDLE if ifu_en_i=0.
- REQ-022: In FULL, ifu_mem_rd_o SHALL be 0, and the FSM SHALL return to FETCH on the cycle after a pop (to IDLE if ifu_en_i=0).
- REQ-023: Deasserting ifu_en_i during FETCH SHALL NOT abort the outstanding read; it completes normally.
- REQ-024: A simultaneous push and pop SHALL leave the count unchanged and preserve byte order.
- REQ-025: A pop SHALL never occur when the FIFO is empty; ifu_byte_valid_o=0 when count=0.
- REQ-026: Flush SHALL empty the FIFO, load the pointer from ifu_pc_i, drop ifu_mem_rd_o the next cycle, and enter IDLE.
- REQ-027: Flush SHALL have priority over an ack or pop in the same cycle; that ack's data is discarded.
- REQ-028: Latency SHALL be: flush at cycle N, ifu_mem_rd_o=1 at N+1, and with ack at N+1, ifu_byte_valid_o=1 at N+2 with ifu_byte_addr_o = the loaded PC.
- REQ-029: All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
- REQ-030: While ifu_reset_i=1 at a clock edge, state SHALL be IDLE, the pointer 0x0000, the FIFO empty, ifu_mem_rd_o=0, ifu_mem_addr_o=0x0000, ifu_byte_o=0x00, ifu_byte_addr_o=0x0000, ifu_byte_valid_o=0 and ifu_fault_o=0.
- REQ-031: Reset SHALL override flush, ack and pop, including a reset asserted mid-read; any late ack after reset is ignored unless a new read is pending.

Configuration
- REQ-032: With macro CORE_IFU_WAIT_TIMEOUT_EN defined, a counter SHALL count FETCH cycles without ack; on reaching TIMEOUT_CYCLES it SHALL set ifu_fault_o=1, drop ifu_mem_rd_o and enter IDLE, and no further reads are issued until a flush or reset.
- REQ-033: ifu_fault_o SHALL be cleared by reset or flush.
- REQ-034: Without CORE_IFU_WAIT_TIMEOUT_EN, no counter SHALL exist, wait is unbounded, and ifu_fault_o SHALL be constant 0.

Verification
- REQ-035: Reset, en=1, zero-wait memory returning addr[7:0], ready=1 -> bytes 0x00, 0x01, 0x02... with addresses 0x0000, 0x0001...; one pop per cycle sustained.
- REQ-036: ready=0, zero-wait memory -> exactly 2 reads issued, then FULL with rd=0; set ready=1 -> head address 0x0000, then 0x0001, then a new read of 0x0002.
- REQ-037: Flush with pc=0xFFFE while a read of 0x0010 is pending with ack in the same cycle -> 0x0010 data discarded; bytes at 0xFFFE, 0xFFFF, 0x0000 follow.
- REQ-038: Memory inserts 3 wait cycles -> rd and addr stable for 4 cycles; the byte is valid the cycle after ack.
- REQ-039: With the macro defined, ack withheld for 15 cycles -> fault=1, rd=0, then flush to 0x0100 -> fault=0 and a read of 0x0100 on the next cycle; without the macro, ack after 40 cycles is accepted and fault stays 0.
- REQ-040: Reset asserted during FETCH with a pending ack -> all outputs at reset values next cycle and the FIFO empty.

Source files
------------

// File: rtl/core_ifu.sv
// core_ifu: byte-wide instruction fetch unit.
// Reads program memory at a 16-bit fetch pointer and hands the bytes to a
// consumer through a 2-entry {byte, address} FIFO with valid/ready handshake.
// A flush restarts fetching at a new PC and drops anything already fetched.
// Optional feature: define CORE_IFU_WAIT_TIMEOUT_EN to bound the number of
// wait cycles per memory read. A read that is never acknowledged then raises a
// sticky fault and stops fetching until the next flush or reset. Without the
// macro the wait is unbounded and ifu_fault_o is constant 0.
module core_ifu #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        ifu_clock_mem_i,
  input  logic        ifu_reset_i,
  input  logic        ifu_en_i,
  input  logic        ifu_flush_i,
  input  logic [15:0] ifu_pc_i,
  output logic [15:0] ifu_mem_addr_o,
  output logic        ifu_mem_rd_o,
  input  logic [7:0]  ifu_mem_data_i,
  input  logic        ifu_mem_ack_i,
  output logic [7:0]  ifu_byte_o,
  output logic [15:0] ifu_byte_addr_o,
  output logic        ifu_byte_valid_o,
  input  logic        ifu_byte_ready_i,
  output logic        ifu_fault_o
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  // A zero timeout would fault before any read could complete.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("core_ifu: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          count_q, count_d;

  // Entry 0 is always the head; entry 1 is only meaningful when count_q == 2.
  logic [DATA_W-1:0]   byte0_q, byte0_d;
  logic [ADDR_W-1:0]   addr0_q, addr0_d;
  logic [DATA_W-1:0]   byte1_q, byte1_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;

  logic                ack_ok;
  logic                pop;
  logic [1:0]          count_post;
  logic                timeout;
  logic                fault_blk;

  // An ack only counts while a read is actually outstanding, so a stray or
  // late ack (e.g. after a reset) is ignored.
  assign ack_ok = (state_q == FETCH) && ifu_mem_ack_i;

  // The consumer can only pop a non-empty FIFO.
  assign pop = (count_q != 2'd0) && ifu_byte_ready_i;

  // Occupancy after this cycle's push and pop (ignoring flush).
  assign count_post = count_q + {1'b0, ack_ok} - {1'b0, pop};

`ifdef CORE_IFU_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;

  // Count un-acked FETCH cycles; the counter restarts on every ack and
  // whenever no read is outstanding. Flush clears the sticky fault.
  always_comb begin
    wait_cnt_d = '0;
    fault_d    = fault_q;
    timeout    = 1'b0;
    if (ifu_flush_i) begin
      fault_d = 1'b0;
    end else if ((state_q == FETCH) && !ifu_mem_ack_i) begin
      if (wait_cnt_q == CNT_LAST) begin
        timeout = 1'b1;
        fault_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // Timeout counter and sticky fault flag.
  always_ff @(posedge ifu_clock_mem_i) begin
    if (ifu_reset_i) begin
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign fault_blk   = fault_q;
  assign ifu_fault_o = fault_q;
`else
  assign timeout     = 1'b0;
  assign fault_blk   = 1'b0;
  assign ifu_fault_o = 1'b0;
`endif

  // Next-state logic: flush wins over ack and pop; otherwise update the FIFO
  // and pointer and pick the next FSM state from the post-update occupancy.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    byte0_d = byte0_q;
    addr0_d = addr0_q;
    byte1_d = byte1_q;
    addr1_d = addr1_q;

    if (ifu_flush_i) begin
      state_d = IDLE;
      ptr_d   = ifu_pc_i;
      count_d = 2'd0;
    end else begin
      // Pop shifts the second entry into the head slot.
      if (pop) begin
        byte0_d = byte1_q;
        addr0_d = addr1_q;
      end

      // Push lands in the first slot that is free after the pop.
      if (ack_ok) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          byte0_d = ifu_mem_data_i;
          addr0_d = ptr_q;
        end else begin
          byte1_d = ifu_mem_data_i;
          addr1_d = ptr_q;
        end
        ptr_d = ptr_q + 16'd1;
      end

      count_d = count_post;

      case (state_q)
        IDLE: begin
          if (ifu_en_i && !fault_blk) begin
            state_d = (count_post == 2'd2) ? FULL : FETCH;
          end
        end
        FETCH: begin
          if (timeout) begin
            state_d = IDLE;
          end else if (ack_ok) begin
            if (!ifu_en_i) begin
              state_d = IDLE;
            end else if (count_post == 2'd2) begin
              state_d = FULL;
            end else begin
              state_d = FETCH;
            end
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ifu_en_i ? FETCH : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, pointer and FIFO registers; reset clears everything so the
  // outputs show zeros while reset is held.
  always_ff @(posedge ifu_clock_mem_i) begin
    if (ifu_reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      byte0_q <= '0;
      addr0_q <= '0;
      byte1_q <= '0;
      addr1_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      byte0_q <= byte0_d;
      addr0_q <= addr0_d;
      byte1_q <= byte1_d;
      addr1_q <= addr1_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign ifu_mem_rd_o     = (state_q == FETCH);
  assign ifu_mem_addr_o   = ptr_q;
  assign ifu_byte_o       = byte0_q;
  assign ifu_byte_addr_o  = addr0_q;
  assign ifu_byte_valid_o = (count_q != 2'd0);

endmodule

// File: tb/tb_core_ifu.sv
// Bench for core_ifu: a behavioural memory responder with random wait states,
// a stream model of the expected fetched bytes, and a scoreboard monitor that
// compares every consumed byte against the model.
module tb_core_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [15:0] pc;
  logic [15:0] mem_addr;
  logic        rd;
  logic [7:0]  mem_data;
  logic        ack;
  logic [7:0]  byte_o;
  logic [15:0] byte_addr;
  logic        valid;
  logic        ready;
  logic        fault;

  always #5 clk = ~clk;

  core_ifu #(.TIMEOUT_CYCLES(15)) dut (
    .ifu_clock_mem_i (clk),
    .ifu_reset_i     (rst),
    .ifu_en_i        (en),
    .ifu_flush_i     (flush),
    .ifu_pc_i        (pc),
    .ifu_mem_addr_o  (mem_addr),
    .ifu_mem_rd_o    (rd),
    .ifu_mem_data_i  (mem_data),
    .ifu_mem_ack_i   (ack),
    .ifu_byte_o      (byte_o),
    .ifu_byte_addr_o (byte_addr),
    .ifu_byte_valid_o(valid),
    .ifu_byte_ready_i(ready),
    .ifu_fault_o     (fault)
  );

  typedef struct packed {
    logic [7:0]  b;
    logic [15:0] a;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        exp_q[$];
  logic [15:0] pop_log[$];
  int          pop_total = 0;
  int          ack_total = 0;
  int          mcount = 0;
  logic [15:0] mptr = 16'h0000;
  logic        hold_ack = 1'b0;
  logic        spurious_en = 1'b0;
  int          wait_lo = 0;
  int          wait_hi = 0;
  int          cur_wait = 0;
  int          wcnt = 0;
  logic        prev_en = 1'b0;
  logic        prev_rd = 1'b0;
  logic        m_push;
  logic        m_pop;
  ent_t        mon_e;

  // Program memory contents: a simple function of the address.
  function automatic logic [7:0] memfn(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Memory responder plus stream model. Runs on the falling edge: first checks
  // the DUT outputs against the model state, then decides the ack for the
  // coming rising edge, then advances the model across that edge.
  always @(negedge clk) begin
    check("valid_vs_model", 32'(valid), 32'(mcount != 0));
    if (rd) begin
      check("rd_addr", 32'(mem_addr), 32'(mptr));
      check("rd_room", 32'(mcount < 2), 32'd1);
      if (!prev_rd) check("rd_needs_en", 32'(prev_en), 32'd1);
    end

    ack      = 1'b0;
    mem_data = 8'($urandom);
    if (rd) begin
      if (!hold_ack) begin
        if (wcnt >= cur_wait) begin
          ack      = 1'b1;
          mem_data = memfn(mem_addr);
          wcnt     = 0;
          cur_wait = $urandom_range(wait_hi, wait_lo);
        end else begin
          wcnt++;
        end
      end
    end else begin
      wcnt     = 0;
      cur_wait = $urandom_range(wait_hi, wait_lo);
      if (spurious_en && (($urandom % 5) == 0)) ack = 1'b1;
    end

    if (rst) begin
      exp_q.delete();
      mcount = 0;
      mptr   = 16'h0000;
    end else if (flush) begin
      exp_q.delete();
      mcount = 0;
      mptr   = pc;
    end else begin
      m_push = ack && rd;
      m_pop  = (mcount != 0) && ready;
      if (m_push) begin
        exp_q.push_back({memfn(mptr), mptr});
        mptr = mptr + 16'd1;
        ack_total++;
      end
      mcount = mcount + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
    prev_en = en;
    prev_rd = rd;
  end

  // Scoreboard monitor: every handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && !flush && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_underflow: got valid byte at 0x%0h, expected no byte", byte_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_byte", 32'(byte_o), 32'(mon_e.b));
        check("pop_addr", 32'(byte_addr), 32'(mon_e.a));
      end
      pop_log.push_back(byte_addr);
      pop_total++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [15:0] a);
    flush = 1'b1;
    pc    = a;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 20 && !rd; k++) tick(1);
    check("rd_start", 32'(rd), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd"},    32'(rd),        32'd0);
    check({tag, "_maddr"}, 32'(mem_addr),  32'd0);
    check({tag, "_byte"},  32'(byte_o),    32'd0);
    check({tag, "_baddr"}, 32'(byte_addr), 32'd0);
    check({tag, "_valid"}, 32'(valid),     32'd0);
    check({tag, "_fault"}, 32'(fault),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; pc = 16'h0000; ready = 1'b0;
    tick(3);
    check_reset("rst0");

    // Streaming from address 0 with zero-wait memory and an always-ready consumer.
    rst = 1'b0; en = 1'b1; ready = 1'b1;
    pop_total = 0;
    pop_log.delete();
    tick(30);
    check("stream_rate", 32'(pop_total >= 27), 32'd1);
    check("stream_first", 32'(pop_log.size() >= 3 ? pop_log[1] : 16'hDEAD), 32'h0001);

    // Consumer stalled: exactly two reads, then rd stays low.
    rst = 1'b1;
    tick(2);
    check_reset("rst1");
    rst = 1'b0; ready = 1'b0; ack_total = 0;
    tick(12);
    check("stall_reads", 32'(ack_total), 32'd2);
    check("stall_rd", 32'(rd), 32'd0);
    check("stall_head", 32'(byte_addr), 32'h0000);
    ready = 1'b1;
    pop_log.delete();
    tick(10);
    check("stall_cnt", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      check("stall_p0", 32'(pop_log[0]), 32'h0000);
      check("stall_p1", 32'(pop_log[1]), 32'h0001);
      check("stall_p2", 32'(pop_log[2]), 32'h0002);
    end

    // Three wait states: request held for four cycles, byte valid after ack.
    wait_lo = 3; wait_hi = 3;
    do_flush(16'h0200);
    wait_rd();
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("wait_rd", 32'(rd), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'h0200);
      check("wait_valid", 32'(valid), 32'd0);
    end
    tick(1);
    check("wait_ack_valid", 32'(valid), 32'd1);
    check("wait_ack_addr", 32'(byte_addr), 32'h0200);
    check("wait_ack_byte", 32'(byte_o), 32'(memfn(16'h0200)));

    // Flush to 0xFFFE in the same cycle as the ack of 0x0010.
    wait_lo = 0; wait_hi = 0; ready = 1'b0; hold_ack = 1'b1;
    do_flush(16'h0010);
    wait_rd();
    check("pend_addr", 32'(mem_addr), 32'h0010);
    flush = 1'b1; pc = 16'hFFFE; hold_ack = 1'b0;
    tick(1);
    flush = 1'b0;
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_rd", 32'(rd), 32'd0);
    ready = 1'b1;
    pop_log.delete();
    tick(12);
    check("wrap_cnt", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      check("wrap_p0", 32'(pop_log[0]), 32'hFFFE);
      check("wrap_p1", 32'(pop_log[1]), 32'hFFFF);
      check("wrap_p2", 32'(pop_log[2]), 32'h0000);
    end

    // Long withheld ack.
    hold_ack = 1'b1;
    do_flush(16'h0300);
    wait_rd();
`ifdef CORE_IFU_WAIT_TIMEOUT_EN
    tick(14);
    check("tmo_pre_rd", 32'(rd), 32'd1);
    check("tmo_pre_fault", 32'(fault), 32'd0);
    tick(1);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_rd", 32'(rd), 32'd0);
    tick(3);
    check("tmo_noread", 32'(rd), 32'd0);
    check("tmo_sticky", 32'(fault), 32'd1);
    hold_ack = 1'b0;
    do_flush(16'h0100);
    check("tmo_clear", 32'(fault), 32'd0);
    tick(1);
    check("tmo_restart_rd", 32'(rd), 32'd1);
    check("tmo_restart_addr", 32'(mem_addr), 32'h0100);
`else
    ready = 1'b0;
    tick(40);
    check("long_rd", 32'(rd), 32'd1);
    check("long_addr", 32'(mem_addr), 32'h0300);
    check("long_fault", 32'(fault), 32'd0);
    hold_ack = 1'b0;
    tick(1);
    check("long_valid", 32'(valid), 32'd1);
    check("long_baddr", 32'(byte_addr), 32'h0300);
    check("long_fault2", 32'(fault), 32'd0);
`endif

    // Reset in the middle of a read whose ack arrives at the reset edge.
    ready = 1'b0; hold_ack = 1'b1;
    do_flush(16'h0400);
    wait_rd();
    rst = 1'b1; hold_ack = 1'b0;
    tick(1);
    check_reset("rst2");
    tick(1);
    rst = 1'b0;

    // Randomized traffic: waits, stalls, enable toggles, flushes, stray acks.
    wait_lo = 0; wait_hi = 2; spurious_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      ready = (($urandom % 4) != 0);
      en    = (($urandom % 8) != 0);
      flush = (($urandom % 50) == 0);
      if (flush) pc = ($urandom % 2 == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom);
      rst   = (($urandom % 400) == 0);
      tick(1);
    end

    // Drain with fetch disabled.
    rst = 1'b0; flush = 1'b0; en = 1'b0; ready = 1'b1; spurious_en = 1'b0;
    tick(20);
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_rd", 32'(rd), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_fault", 32'(fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
